// File: rtl/pattern_serializer.sv
// Parallel-to-serial pattern source feeding the 10101 sequence detector.
// Patterns load over valid/ready, then shift out MSB-first with stall and last-bit marking.
module pattern_serializer #(
  parameter int   WIDTH    = 11,
  parameter int   LEN_W    = 4,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LEN_W-1:0] load_len,
  input  logic             stall,
  output logic             sdata,
  output logic             svalid,
  output logic             done
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [LEN_W-1:0] rem;
  logic [LEN_W-1:0] len_c;
  logic [WIDTH-1:0] aligned;
  logic             accept;

  // A zero or oversize length means "the whole word".
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    if (len == '0 || int'(len) > WIDTH) return LEN_W'(WIDTH);
    return len;
  endfunction

  // Moves bit len-1 of the pattern to the MSB so emission is always from the top.
  function automatic logic [WIDTH-1:0] align_msb(input logic [WIDTH-1:0] data,
                                                 input logic [LEN_W-1:0] len);
    return data << (LEN_W'(WIDTH) - len);
  endfunction

  assign len_c      = clamp_len(load_len);
  assign aligned    = align_msb(load_data, len_c);
  // rem == 0 in SHIFT means the last bit is on sdata, so the next pattern may follow gaplessly.
  assign load_ready = rst && (state == IDLE || rem == '0);
  assign accept     = load_valid && load_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      sr     <= '0;
      rem    <= '0;
      sdata  <= IDLE_BIT;
      svalid <= 1'b0;
      done   <= 1'b0;
    end else if (accept) begin
      state  <= SHIFT;
      sdata  <= aligned[WIDTH-1];
      svalid <= 1'b1;
      done   <= (len_c == LEN_W'(1));
      sr     <= aligned << 1;
      rem    <= len_c - LEN_W'(1);
    end else if (state == SHIFT && rem != '0) begin
      if (stall) begin
        sdata  <= IDLE_BIT;
        svalid <= 1'b0;
        done   <= 1'b0;
      end else begin
        sdata  <= sr[WIDTH-1];
        svalid <= 1'b1;
        done   <= (rem == LEN_W'(1));
        sr     <= sr << 1;
        rem    <= rem - LEN_W'(1);
      end
    end else begin
      state  <= IDLE;
      sdata  <= IDLE_BIT;
      svalid <= 1'b0;
      done   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pattern_serializer.sv
// Bench for pattern_serializer: directed vector table, reset corner cases,
// and a randomized run against a queue-based reference model.
module tb_pattern_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [10:0] load_data = '0;
  logic [3:0]  load_len = '0;
  logic        stall = 1'b0;
  logic        sdata, svalid, done;

  int checks = 0;
  int failures = 0;

  pattern_serializer #(.WIDTH(11), .LEN_W(4), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_len(load_len), .stall(stall),
    .sdata(sdata), .svalid(svalid), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        lv;
    logic [10:0] d;
    logic [3:0]  l;
    logic        st;
    logic [3:0]  exp;  // {sdata, svalid, done, load_ready} after the edge
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic lv, logic [10:0] d, logic [3:0] l, logic st,
                              logic sd, logic sv, logic dn, logic rdy);
    vec_t v;
    v.lv = lv; v.d = d; v.l = l; v.st = st; v.exp = {sd, sv, dn, rdy};
    tbl.push_back(v);
  endfunction

  task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got {sdata,svalid,done,ready}=%b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [3:0] outs();
    return {sdata, svalid, done, load_ready};
  endfunction

  // Reference model: bits of the current pattern not yet on sdata, in emission order.
  bit pend[$];

  function automatic int clamp(logic [3:0] l);
    return (l == 0 || l > 11) ? 11 : int'(l);
  endfunction

  function automatic logic [3:0] model_edge(logic lv, logic [10:0] d, logic [3:0] l, logic st);
    logic sd, sv, dn;
    int   len;
    sd = 1'b0; sv = 1'b0; dn = 1'b0;
    if (lv && pend.size() == 0) begin
      len = clamp(l);
      sd = d[len-1]; sv = 1'b1; dn = (len == 1);
      for (int i = len - 2; i >= 0; i--) pend.push_back(d[i]);
    end else if (pend.size() != 0 && !st) begin
      sd = pend.pop_front(); sv = 1'b1; dn = (pend.size() == 0);
    end
    return {sd, sv, dn, (pend.size() == 0)};
  endfunction

  initial begin
    // Single 10-bit pattern 1101010100
    add(1, 11'b01101010100, 10, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1);
    // Back-to-back: 10101 then 011 offered on A's last cycle
    add(1, 11'b10101, 5, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 1, 1, 1);
    add(1, 11'b011, 3, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 1, 1, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1);
    // Stall two edges after the first bit of 1011
    add(1, 11'b1011, 4, 0, 1, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 1, 1, 1, 1);
    // len=1 accepted despite stall, then len=0 -> 11 ones gaplessly
    add(1, 11'b1, 1, 1, 1, 1, 1, 1);
    add(1, 11'h7FF, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 10; i++) add(0, 0, 0, 0, 1, 1, (i == 9), (i == 9));
    // len=15 clamps to 11
    add(1, 11'b10000000001, 15, 0, 1, 1, 0, 0);
    for (int i = 0; i < 9; i++) add(0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 1, 1, 1);
    add(0, 0, 0, 1, 0, 0, 0, 1);

    // Reset held with load_valid high
    load_valid = 1'b1;
    load_data  = 11'h7FF;
    #1 rst = 1'b0;
    #1 chk("reset_async", outs(), 4'b0000);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("reset_hold", outs(), 4'b0000);
    end
    load_valid = 1'b0;
    @(negedge clk) rst = 1'b1;
    #1 chk("reset_release_ready", outs(), 4'b0001);
    @(posedge clk); #1;
    chk("idle_after_reset", outs(), 4'b0001);

    // Directed table
    foreach (tbl[i]) begin
      load_valid = tbl[i].lv; load_data = tbl[i].d; load_len = tbl[i].l; stall = tbl[i].st;
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end
    load_valid = 1'b0; stall = 1'b0;

    // Reset mid-pattern at bit 3 of a 10-bit pattern
    load_valid = 1'b1; load_data = 11'b01111111111; load_len = 10;
    @(posedge clk); #1;
    load_valid = 1'b0;
    load_data  = '0;
    chk("midrst_bit1", outs(), 4'b1100);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midrst_bit3", outs(), 4'b1100);
    #1 rst = 1'b0;
    #1 chk("midrst_immediate", outs(), 4'b0000);
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_resume", outs(), 4'b0001);
    end

    // Randomized run against the queue model
    pend.delete();
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] e;
      load_valid = ($urandom_range(0, 99) < 45);
      load_data  = 11'($urandom);
      load_len   = 4'($urandom_range(0, 15));
      stall      = ($urandom_range(0, 99) < 30);
      e = model_edge(load_valid, load_data, load_len, stall);
      @(posedge clk); #1;
      chk("random", outs(), e);
    end
    load_valid = 1'b0; stall = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
